// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - modulo-N up/down counter with load, cascade carry and wrap pulse
// Optional saturation instead of wrap-around when MODN_SATURATE_EN is defined.
module modn_updown_counter #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ld_err
);

    // Top count kept in WIDTH bits so MODULUS == 2**WIDTH never overflows a compare.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ld_err_q, ld_err_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        ld_err_d = ld_err_q;
        if (load) begin
            if (din > MAX_VAL) begin
                count_d  = MAX_VAL;
                ld_err_d = 1'b1;
            end else begin
                count_d  = din;
            end
        end else if (en) begin
            if (up) begin
`ifdef MODN_SATURATE_EN
                if (!at_max) begin
                    count_d = count_q + ONE;
                    wrap_d  = ((count_q + ONE) == MAX_VAL);
                end
`else
                if (at_max) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
`endif
            end else begin
`ifdef MODN_SATURATE_EN
                if (!at_zero) begin
                    count_d = count_q - ONE;
                    wrap_d  = (count_q == ONE);
                end
`else
                if (at_zero) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            ld_err_q <= ld_err_d;
        end
    end

    // Zero-latency carry so a following stage can use it directly as its enable.
    assign tc     = en & ~load & (up ? at_max : at_zero);
    assign count  = count_q;
    assign wrap   = wrap_q;
    assign ld_err = ld_err_q;

endmodule
